axis_l2_addr_swap: RTL
======================

// Module: axis_l2_addr_swap
// PURPOSE
//  Sits directly downstream of the slave-loopback AXI-Stream FIFO, on the TX clock side.
//  Buffers the first three 32-bit beats (12 bytes) of each Ethernet frame.
//  When enabled, it swaps the destination and source MAC addresses, then passes the rest of the frame through.
//  It also counts completed frames and drives the loopback activity LED.
// PARAMETERS
//  CNT_W      16  width of frame counter frame_cnt
//  FLASH_BIT  13  frame_cnt bit driven onto mtrlb_activity_flash (must be < CNT_W)
// PORTS
//  axis_tx_clk            in   1      single clock; all logic is on the rising edge
//  axis_resetn            in   1      asynchronous, active-low reset
//  slvlb_en_l2_addr_swap  in   1      swap enable; sampled on the first accepted beat of each frame
//  s_axis_tdata           in   32     input data; byte0 = [7:0] = first byte on the wire
//  s_axis_tkeep           in   4      input byte enables
//  s_axis_tvalid          in   1      input valid
//  s_axis_tlast           in   1      input end of frame
//  s_axis_tuser           in   1      input error flag, forwarded per beat
//  s_axis_tready          out  1      input ready
//  m_axis_tdata/tkeep     out  32/4   output data and byte enables
//  m_axis_tvalid/tlast    out  1/1    output valid and end of frame
//  m_axis_tuser           out  1      output error flag
//  m_axis_tready          in   1      output ready
//  frame_cnt              out  CNT_W  count of output beats with tlast accepted (tvalid & tready & tlast); wraps
//  mtrlb_activity_flash   out  1      frame_cnt[FLASH_BIT]
// BEHAVIOUR
//  Reset: state=S_HDR, header count=0, m_axis_tvalid=0, frame_cnt=0, s_axis_tready=0 while reset is asserted.
//   All m_* data/keep/last/user outputs reset to 0.
//  All m_* outputs come from one output register. They are held stable while tvalid=1 and tready=0.
//  S_HDR:
//   - s_axis_tready=1; each accepted beat is stored in hdr[cnt], then cnt++.
//   - swap_q is latched on the cnt=0 beat.
//   - Go to S_HOUT when the 3rd beat is accepted, or on an earlier tlast (short frame, n<3 beats).
//  S_HOUT:
//   - s_axis_tready=0; emits hdr[0..n-1], one per output handshake.
//   - Swap is applied only if swap_q=1, n=3, all three tkeep=4'hF, and tlast is absent on beats 0 and 1.
//   - Swapped words:
//       out0={h2[15:0],h1[31:16]}
//       out1={h0[15:0],h2[31:16]}
//       out2={h1[15:0],h0[31:16]}
//   - tkeep, tlast and tuser stay with their beat position.
//   - After the last hdr beat is accepted: go to S_HDR if that beat had tlast, else to S_BODY.
//  S_BODY:
//   - Pipeline register; s_axis_tready = m_axis_tready | ~m_axis_tvalid.
//   - Beats are forwarded unchanged with 1-cycle latency.
//   - When a tlast beat is accepted on the input, go to S_HDR.
//  Latency:
//   - First output beat is valid 1 cycle after the 3rd header beat (or the short-frame tlast) is accepted.
//   - Each frame incurs a 3-cycle input stall while the header drains.
//  tlast on the 3rd beat (12-byte frame): swap is still applied; return to S_HDR after emission.
//  A toggle of slvlb_en_l2_addr_swap mid-frame has no effect until the next frame.
//  frame_cnt wraps from 2^CNT_W-1 to 0. No saturation.
//  Input tvalid low mid-frame: the FSM holds its state; no beat is generated or dropped.
//  Reset asserted mid-frame:
//   - The partial frame is discarded and m_axis_tvalid drops immediately.
//   - The upstream FIFO and downstream consumer share axis_resetn.
// TESTING
//  T1 swap=1, 16-beat frame, h0=32'h33221100, h1=32'h77665544, h2=32'hBBAA9988
//     -> out 99887766, 1100BBAA, 55443322; beats 3..15 identical; frame_cnt=1.
//  T2 swap=0, same frame -> output bit-identical to input, including tkeep/tuser per beat.
//  T3 swap=1, 2-beat frame (tlast on beat1, tkeep=4'h3) -> passed unchanged, tlast on beat1, next frame swapped normally.
//  T4 swap=1, 100 back-to-back frames, random 50% m_axis_tready and s_axis_tvalid gaps
//     -> no beat lost, duplicated or reordered vs. reference model; frame_cnt=100.
//  T5 swap toggled 1->0 at beat 5 of frame A -> A swapped; next frame B unswapped.
//  T6 axis_resetn pulsed low during beat 1 of header, then a clean frame
//     -> m_axis_tvalid=0 during reset, frame_cnt=0, clean frame correctly swapped.
//  T7 8192 minimal frames -> mtrlb_activity_flash rises on the 8192nd frame;
//     preload-free wrap check at 65536 frames -> frame_cnt=0.

Source files
------------

// File: rtl/axis_l2_addr_swap.sv
// axis_l2_addr_swap: swaps the destination and source MAC addresses of each Ethernet frame on an AXI-Stream path
//   and counts completed frames.
// Ports:
//   axis_tx_clk / axis_resetn    clock, asynchronous active-low reset
//   slvlb_en_l2_addr_swap        swap enable, sampled on the first beat of each frame
//   s_axis_*                     32-bit input stream (tdata, tkeep, tvalid, tlast, tuser, tready)
//   m_axis_*                     32-bit output stream, driven from a single output register
//   frame_cnt                    wrapping count of output tlast handshakes
//   mtrlb_activity_flash         frame_cnt[FLASH_BIT], drives the loopback activity LED
module axis_l2_addr_swap #(
    parameter int CNT_W     = 16,
    parameter int FLASH_BIT = 13
) (
    input  logic             axis_tx_clk,
    input  logic             axis_resetn,
    input  logic             slvlb_en_l2_addr_swap,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             mtrlb_activity_flash
);
    typedef enum logic [1:0] {S_HDR, S_HOUT, S_BODY} state_t;
    state_t      state, state_nx;
    logic [31:0] hdr_data [3];
    logic [3:0]  hdr_keep [3];
    logic [2:0]  hdr_last, hdr_user;
    logic [1:0]  cnt, ocnt;
    logic        swap_q, s_fire, out_free, hout_load, body_load, last_hdr, do_swap;
    logic [31:0] swap_word, hout_data;

    assign s_fire    = s_axis_tvalid & s_axis_tready;
    assign out_free  = ~m_axis_tvalid | m_axis_tready;
    assign hout_load = (state == S_HOUT) && out_free;
    assign body_load = (state == S_BODY) && s_fire;
    // In S_HOUT cnt holds the number of buffered header beats (1..3)
    assign last_hdr  = ocnt == cnt - 2'd1;
    assign do_swap   = swap_q && cnt == 2'd3 && !hdr_last[0] && !hdr_last[1] &&
                       hdr_keep[0] == 4'hF && hdr_keep[1] == 4'hF && hdr_keep[2] == 4'hF;
    // Ready is forced low while reset is held so the shared upstream FIFO cannot hand over a beat
    assign s_axis_tready = axis_resetn && (state == S_HDR || (state == S_BODY && out_free));
    assign mtrlb_activity_flash = frame_cnt[FLASH_BIT];

    // Bytes 0-5 (destination) and 6-11 (source) exchange places across the 12-byte header
    always_comb begin
        swap_word = ocnt == 2'd0 ? {hdr_data[2][15:0], hdr_data[1][31:16]} :
                    ocnt == 2'd1 ? {hdr_data[0][15:0], hdr_data[2][31:16]} :
                                   {hdr_data[1][15:0], hdr_data[0][31:16]};
        hout_data = do_swap ? swap_word : hdr_data[ocnt];
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_HDR:   if (s_fire && (cnt == 2'd2 || s_axis_tlast)) state_nx = S_HOUT;
            S_HOUT:  if (out_free && last_hdr) state_nx = hdr_last[ocnt] ? S_HDR : S_BODY;
            S_BODY:  if (s_fire && s_axis_tlast) state_nx = S_HDR;
            default: state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge axis_tx_clk or negedge axis_resetn) begin
        if (!axis_resetn) state <= S_HDR;
        else state <= state_nx;
    end

    always_ff @(posedge axis_tx_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int i = 0; i < 3; i++) begin
                hdr_data[i] <= '0;
                hdr_keep[i] <= '0;
            end
            hdr_last      <= '0;
            hdr_user      <= '0;
            cnt           <= '0;
            ocnt          <= '0;
            swap_q        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            if (state == S_HDR && s_fire) begin
                hdr_data[cnt] <= s_axis_tdata;
                hdr_keep[cnt] <= s_axis_tkeep;
                hdr_last[cnt] <= s_axis_tlast;
                hdr_user[cnt] <= s_axis_tuser;
                if (cnt == 2'd0) swap_q <= slvlb_en_l2_addr_swap;
                cnt  <= cnt + 2'd1;
                ocnt <= 2'd0;
            end
            if (hout_load) begin
                ocnt <= ocnt + 2'd1;
                if (last_hdr) cnt <= 2'd0;
            end
            // The output register drains a pending beat in S_HDR and is reloaded in S_HOUT/S_BODY
            if (hout_load || body_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= hout_load ? hout_data : s_axis_tdata;
                m_axis_tkeep  <= hout_load ? hdr_keep[ocnt] : s_axis_tkeep;
                m_axis_tlast  <= hout_load ? hdr_last[ocnt] : s_axis_tlast;
                m_axis_tuser  <= hout_load ? hdr_user[ocnt] : s_axis_tuser;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
endmodule
